// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_scoreboard: decode-stage hazard unit with per-register countdown scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS         = 32,
  parameter int REG_ADDR_W       = 5,
  parameter int FORWARD_EN       = 1,
  parameter int ALU_STALL_NOFWD  = 2,
  parameter int LOAD_STALL_NOFWD = 2,
  parameter int LOAD_STALL_FWD   = 1,
  parameter int MAX_STALL        = 15,
  parameter int STALL_CNT_W      = $clog2(MAX_STALL + 1)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_branch_op,
  input  logic                   branch_taken,
  input  logic                   ext_stall,
  output logic                   PCWrite,
  output logic                   DecodeRegWrite,
  output logic                   MuxControl,
  output logic                   flushControl,
  output logic [NUM_REGS-1:0]    pending_mask,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   stall_timeout
);

  localparam int MAX_A  = (ALU_STALL_NOFWD > LOAD_STALL_NOFWD) ? ALU_STALL_NOFWD : LOAD_STALL_NOFWD;
  localparam int MAX_B  = (MAX_A > LOAD_STALL_FWD) ? MAX_A : LOAD_STALL_FWD;
  localparam int CNT_W  = (MAX_B < 1) ? 1 : $clog2(MAX_B + 1);

  localparam logic [CNT_W-1:0]       c_aluWb    = CNT_W'(ALU_STALL_NOFWD);
  localparam logic [CNT_W-1:0]       c_loadWb   = CNT_W'(LOAD_STALL_NOFWD);
  localparam logic [CNT_W-1:0]       c_loadFwd  = CNT_W'(LOAD_STALL_FWD);
  localparam logic [STALL_CNT_W-1:0] c_maxStall = STALL_CNT_W'(MAX_STALL);
  localparam logic                   c_noFwd    = (FORWARD_EN == 0);

  logic [CNT_W-1:0]       w_fwdCnt [NUM_REGS];
  logic [CNT_W-1:0]       w_wbCnt  [NUM_REGS];
  logic                   w_useWb;
  logic [CNT_W-1:0]       w_rsCnt;
  logic [CNT_W-1:0]       w_rtCnt;
  logic                   w_hazard;
  logic                   w_stall;
  logic                   w_issue;
  logic [STALL_CNT_W-1:0] w_nextStallCnt;
  logic [STALL_CNT_W-1:0] r_stallCnt;
  logic                   r_timeout;

  // Branches compare operands in decode, so they must wait for writeback even with forwarding.
  assign w_useWb  = id_branch_op | c_noFwd;
  assign w_rsCnt  = w_useWb ? w_wbCnt[id_rs] : w_fwdCnt[id_rs];
  assign w_rtCnt  = w_useWb ? w_wbCnt[id_rt] : w_fwdCnt[id_rt];
  assign w_hazard = id_valid &
                    ((id_uses_rs & (id_rs != '0) & (w_rsCnt != '0)) |
                     (id_uses_rt & (id_rt != '0) & (w_rtCnt != '0)));

  // Reset forces the pipeline enables open while it is asserted.
  assign w_stall  = (w_hazard | ext_stall) & ~branch_taken & ~Reset;
  assign w_issue  = id_valid & ~w_stall & ~branch_taken;

  assign PCWrite        = ~w_stall;
  assign DecodeRegWrite = ~w_stall;
  assign MuxControl     = ~w_stall & ~branch_taken;
  assign flushControl   = branch_taken;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_fwdCnt[r]     = '0;
      assign w_wbCnt[r]      = '0;
      assign pending_mask[r] = 1'b0;
    end else begin : g_cnt
      logic             r_fwd;
      logic [CNT_W-1:0] r_fwdCnt;
      logic [CNT_W-1:0] r_wbCnt;
      logic             w_load;

      assign w_load = w_issue & id_reg_write & (id_rd == REG_ADDR_W'(r));

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          r_fwdCnt <= '0;
          r_wbCnt  <= '0;
        end else if (w_load) begin
          r_wbCnt  <= id_mem_read ? c_loadWb : c_aluWb;
          r_fwdCnt <= id_mem_read ? c_loadFwd : '0;
        end else begin
          if (r_wbCnt != '0)  r_wbCnt  <= r_wbCnt - CNT_W'(1);
          if (r_fwdCnt != '0) r_fwdCnt <= r_fwdCnt - CNT_W'(1);
        end
      end

      assign r_fwd           = (r_fwdCnt != '0);
      assign w_fwdCnt[r]     = r_fwdCnt;
      assign w_wbCnt[r]      = r_wbCnt;
      assign pending_mask[r] = r_fwd | (r_wbCnt != '0);
    end
  end

  always_comb begin
    w_nextStallCnt = '0;
    if (w_stall) begin
      w_nextStallCnt = (r_stallCnt == c_maxStall) ? r_stallCnt : r_stallCnt + STALL_CNT_W'(1);
    end
  end

  // Timeout rises on the same edge the count reaches its ceiling.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_stallCnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_stallCnt <= w_nextStallCnt;
      if (w_stall && (w_nextStallCnt == c_maxStall)) r_timeout <= 1'b1;
    end
  end

  assign stall_count   = r_stallCnt;
  assign stall_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// tb_hazard_scoreboard: directed checks on a forwarding and a non-forwarding instance.
module tb_hazard_scoreboard;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_branch_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       branch_taken, ext_stall;

  logic        PCWriteF, DecodeRegWriteF, MuxControlF, flushControlF, stall_timeoutF;
  logic [31:0] pending_maskF;
  logic [2:0]  stall_countF;
  logic        PCWriteN, DecodeRegWriteN, MuxControlN, flushControlN, stall_timeoutN;
  logic [31:0] pending_maskN;
  logic [2:0]  stall_countN;

  int nAssert = 0;
  int nFail   = 0;

  always #5 Clk = ~Clk;

  hazard_scoreboard #(.FORWARD_EN(1), .MAX_STALL(4)) dutF (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_branch_op(id_branch_op), .branch_taken(branch_taken),
    .ext_stall(ext_stall), .PCWrite(PCWriteF), .DecodeRegWrite(DecodeRegWriteF),
    .MuxControl(MuxControlF), .flushControl(flushControlF), .pending_mask(pending_maskF),
    .stall_count(stall_countF), .stall_timeout(stall_timeoutF));

  hazard_scoreboard #(.FORWARD_EN(0), .MAX_STALL(4)) dutN (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_branch_op(id_branch_op), .branch_taken(branch_taken),
    .ext_stall(ext_stall), .PCWrite(PCWriteN), .DecodeRegWrite(DecodeRegWriteN),
    .MuxControl(MuxControlN), .flushControl(flushControlN), .pending_mask(pending_maskN),
    .stall_count(stall_countN), .stall_timeout(stall_timeoutN));

  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0; id_mem_read = 0;
    id_branch_op = 0; id_rs = 0; id_rt = 0; id_rd = 0; branch_taken = 0; ext_stall = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  task automatic instr(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic wr, input logic ld, input logic br);
    id_valid = 1; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_rd = rd; id_reg_write = wr; id_mem_read = ld; id_branch_op = br;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1;
    repeat (2) step();
    Reset = 0;
    step();
    #1;
    nAssert++; if (pending_maskF !== 32'h0) begin nFail++; $display("FAIL rst_pending: got %h want 0", pending_maskF); end
    nAssert++; if (stall_countF !== 3'd0) begin nFail++; $display("FAIL rst_count: got %0d want 0", stall_countF); end
    nAssert++; if (stall_timeoutF !== 1'b0) begin nFail++; $display("FAIL rst_timeout: got %b want 0", stall_timeoutF); end
    nAssert++; if ({PCWriteF, DecodeRegWriteF, MuxControlF, flushControlF} !== 4'b1110) begin
      nFail++; $display("FAIL rst_ctrl: got %b want 1110", {PCWriteF, DecodeRegWriteF, MuxControlF, flushControlF}); end
  endtask

  task automatic test_load_use();
    instr(0, 0, 0, 0, 8, 1, 1, 0);          // lw $8
    #1;
    nAssert++; if (PCWriteF !== 1'b1) begin nFail++; $display("FAIL lu_c0_issue: got %b want 1", PCWriteF); end
    step();
    instr(8, 1, 8, 1, 9, 1, 0, 0);          // add $9,$8,$8
    #1;
    nAssert++; if ({PCWriteF, DecodeRegWriteF, MuxControlF} !== 3'b000) begin
      nFail++; $display("FAIL lu_c1_stall: got %b want 000", {PCWriteF, DecodeRegWriteF, MuxControlF}); end
    nAssert++; if (pending_maskF[8] !== 1'b1) begin nFail++; $display("FAIL lu_c1_pend8: got %b want 1", pending_maskF[8]); end
    step();
    #1;
    nAssert++; if (PCWriteF !== 1'b1 || MuxControlF !== 1'b1) begin
      nFail++; $display("FAIL lu_c2_issue: got pcw=%b mux=%b want 1 1", PCWriteF, MuxControlF); end
    nAssert++; if (pending_maskF[8] !== 1'b1) begin nFail++; $display("FAIL lu_c2_pend8: got %b want 1", pending_maskF[8]); end
    nAssert++; if (PCWriteN !== 1'b0) begin nFail++; $display("FAIL lu_c2_nofwd_stall: got %b want 0", PCWriteN); end
    nAssert++; if (stall_countF !== 3'd1) begin nFail++; $display("FAIL lu_c2_count: got %0d want 1", stall_countF); end
    step();
    idle();
    #1;
    nAssert++; if (pending_maskF !== 32'h0000_0200) begin nFail++; $display("FAIL lu_c3_pend: got %h want 00000200", pending_maskF); end
    nAssert++; if (stall_countF !== 3'd0) begin nFail++; $display("FAIL lu_c3_count: got %0d want 0", stall_countF); end
    drain();
  endtask

  task automatic test_branch();
    instr(0, 0, 0, 0, 5, 1, 0, 0);          // add $5
    step();
    instr(5, 1, 0, 1, 0, 0, 0, 1);          // beq $5,$0
    #1;
    nAssert++; if (PCWriteF !== 1'b0) begin nFail++; $display("FAIL br_c1_stall: got %b want 0", PCWriteF); end
    step();
    #1;
    nAssert++; if (PCWriteF !== 1'b0) begin nFail++; $display("FAIL br_c2_stall: got %b want 0", PCWriteF); end
    nAssert++; if (stall_countF !== 3'd1) begin nFail++; $display("FAIL br_c2_count: got %0d want 1", stall_countF); end
    step();
    #1;
    nAssert++; if (PCWriteF !== 1'b1) begin nFail++; $display("FAIL br_c3_issue: got %b want 1", PCWriteF); end
    nAssert++; if (stall_countF !== 3'd2) begin nFail++; $display("FAIL br_c3_count: got %0d want 2", stall_countF); end
    step();
    idle();
    #1;
    nAssert++; if (stall_countF !== 3'd0) begin nFail++; $display("FAIL br_c4_count: got %0d want 0", stall_countF); end
    drain();
  endtask

  task automatic test_nofwd();
    instr(0, 0, 0, 0, 5, 1, 0, 0);          // add $5
    step();
    instr(5, 1, 0, 0, 7, 1, 0, 0);          // sub $7,$5
    #1;
    nAssert++; if (PCWriteN !== 1'b0) begin nFail++; $display("FAIL nf_c1_stall: got %b want 0", PCWriteN); end
    nAssert++; if (PCWriteF !== 1'b1) begin nFail++; $display("FAIL nf_c1_fwd_nostall: got %b want 1", PCWriteF); end
    step();
    #1;
    nAssert++; if (PCWriteN !== 1'b0) begin nFail++; $display("FAIL nf_c2_stall: got %b want 0", PCWriteN); end
    nAssert++; if (stall_countN !== 3'd1) begin nFail++; $display("FAIL nf_c2_count: got %0d want 1", stall_countN); end
    step();
    #1;
    nAssert++; if (PCWriteN !== 1'b1) begin nFail++; $display("FAIL nf_c3_issue: got %b want 1", PCWriteN); end
    nAssert++; if (stall_countN !== 3'd2) begin nFail++; $display("FAIL nf_c3_count: got %0d want 2", stall_countN); end
    step();
    instr(0, 0, 0, 0, 5, 1, 0, 0);          // add $5
    step();
    instr(0, 0, 0, 0, 5, 1, 0, 0);          // add $5 again, reloads the counter
    step();
    instr(5, 1, 0, 0, 7, 1, 0, 0);          // sub $7,$5
    #1;
    nAssert++; if (pending_maskN[5] !== 1'b1) begin nFail++; $display("FAIL nf_c6_pend5: got %b want 1", pending_maskN[5]); end
    nAssert++; if (PCWriteN !== 1'b0) begin nFail++; $display("FAIL nf_c6_stall: got %b want 0", PCWriteN); end
    step();
    #1;
    nAssert++; if (PCWriteN !== 1'b0) begin nFail++; $display("FAIL nf_c7_reload_stall: got %b want 0", PCWriteN); end
    step();
    #1;
    nAssert++; if (PCWriteN !== 1'b1) begin nFail++; $display("FAIL nf_c8_issue: got %b want 1", PCWriteN); end
    drain();
  endtask

  task automatic test_flush();
    instr(0, 0, 0, 0, 5, 1, 0, 0);          // add $5
    step();
    instr(5, 1, 0, 0, 10, 1, 0, 1);         // consumer of $5 writing $10
    #1;
    nAssert++; if (PCWriteF !== 1'b0) begin nFail++; $display("FAIL fl_c1_stall: got %b want 0", PCWriteF); end
    step();
    branch_taken = 1;
    #1;
    nAssert++; if ({PCWriteF, DecodeRegWriteF, MuxControlF, flushControlF} !== 4'b1101) begin
      nFail++; $display("FAIL fl_c2_ctrl: got %b want 1101", {PCWriteF, DecodeRegWriteF, MuxControlF, flushControlF}); end
    nAssert++; if (stall_countF !== 3'd1) begin nFail++; $display("FAIL fl_c2_count: got %0d want 1", stall_countF); end
    step();
    idle();
    #1;
    nAssert++; if (stall_countF !== 3'd0) begin nFail++; $display("FAIL fl_c3_count: got %0d want 0", stall_countF); end
    nAssert++; if (pending_maskF[10] !== 1'b0) begin nFail++; $display("FAIL fl_c3_noissue: got %b want 0", pending_maskF[10]); end
    drain();
  endtask

  task automatic test_zero_reg();
    instr(0, 0, 0, 0, 0, 1, 1, 0);          // lw $0
    step();
    instr(0, 1, 0, 1, 3, 1, 0, 1);          // branch reading $0,$0
    #1;
    nAssert++; if (pending_maskF !== 32'h0 || pending_maskN !== 32'h0) begin
      nFail++; $display("FAIL z_pend: got %h/%h want 0/0", pending_maskF, pending_maskN); end
    nAssert++; if (PCWriteF !== 1'b1 || PCWriteN !== 1'b1) begin
      nFail++; $display("FAIL z_nostall: got %b/%b want 1/1", PCWriteF, PCWriteN); end
    drain();
  endtask

  task automatic test_timeout();
    logic [2:0] expCnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    ext_stall = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      #1;
      nAssert++; if (stall_countF !== expCnt[i]) begin nFail++; $display("FAIL to_count%0d: got %0d want %0d", i, stall_countF, expCnt[i]); end
      nAssert++; if (stall_timeoutF !== (i >= 3)) begin nFail++; $display("FAIL to_flag%0d: got %b want %b", i, stall_timeoutF, (i >= 3)); end
    end
    ext_stall = 0;
    instr(0, 0, 0, 0, 5, 1, 0, 0);          // add $5
    step();
    idle();
    ext_stall = 1;
    #1;
    nAssert++; if (stall_timeoutF !== 1'b1) begin nFail++; $display("FAIL to_sticky: got %b want 1", stall_timeoutF); end
    nAssert++; if (pending_maskF[5] !== 1'b1 || PCWriteF !== 1'b0) begin
      nFail++; $display("FAIL to_prereset: got pend5=%b pcw=%b want 1 0", pending_maskF[5], PCWriteF); end
    Reset = 1;
    #1;
    nAssert++; if (stall_timeoutF !== 1'b0) begin nFail++; $display("FAIL to_rst_flag: got %b want 0", stall_timeoutF); end
    nAssert++; if (pending_maskF !== 32'h0) begin nFail++; $display("FAIL to_rst_pend: got %h want 0", pending_maskF); end
    nAssert++; if (PCWriteF !== 1'b1 || stall_countF !== 3'd0) begin
      nFail++; $display("FAIL to_rst_ctrl: got pcw=%b cnt=%0d want 1 0", PCWriteF, stall_countF); end
    #1;
    Reset = 0;
    drain();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_nofwd();
    test_flush();
    test_zero_reg();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
`default_nettype wire
